// File: rtl/ladybird_mem_unit.sv
// ladybird_mem_unit: memory access unit of the ladybird multi-cycle RV32I core.
//
// This unit has two independent sides, and both may be busy at the same time.
//  - The fetch side turns a pc request into one ibus read. The fetched word is
//    returned on inst, and inst_valid pulses for one cycle.
//  - The data side turns a load or store into one byte-lane-aligned dbus word
//    transaction. The extended load result is held on o_data/o_valid until o_ready.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   pc, pc_valid, pc_ready            fetch request handshake
//   inst, inst_valid                  fetched instruction, one-cycle valid pulse
//   i_valid, i_ready, i_addr, i_data,
//   i_we, i_funct                     load/store request (funct3 size encoding)
//   o_valid, o_data, o_ready          load result handshake
//   ibus_req/gnt/addr/rvalid/rdata    instruction bus
//   dbus_req/gnt/addr/we/wstrb/wdata,
//   dbus_rvalid/rdata                 data bus
//   misaligned                        one-cycle pulse after accepting a misaligned request
//
// Optional feature macro: LADYBIRD_MEM_MISALIGN_EN
//   When it is defined, a misaligned H or W request is accepted but issues no bus
//   transaction. Such a load returns o_data=0.
//   When it is undefined, misaligned is tied low. H selects its lane with addr[1]
//   only, and W ignores addr[1:0].
module ladybird_mem_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_we,
  input  logic [2:0]      i_funct,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  input  logic            o_ready,
  output logic            ibus_req,
  input  logic            ibus_gnt,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_rvalid,
  input  logic [XLEN-1:0] ibus_rdata,
  output logic            dbus_req,
  input  logic            dbus_gnt,
  output logic [XLEN-1:0] dbus_addr,
  output logic            dbus_we,
  output logic [3:0]      dbus_wstrb,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            misaligned
);

  typedef enum logic [1:0] {FIdle, FReq, FWait} fetch_state_e;
  typedef enum logic [2:0] {DIdle, DReq, DWait, DResp, DMis} data_state_e;

  // ---------------------------------------------------------------------------
  // Fetch side
  // ---------------------------------------------------------------------------
  fetch_state_e    fetch_state;
  logic [XLEN-3:0] pc_word;
  logic            unused_pc_bits;

  // The fetch address is word aligned, so the low pc bits carry no information.
  assign unused_pc_bits = ^pc[1:0];

  assign pc_ready  = (fetch_state == FIdle);
  assign ibus_req  = (fetch_state == FReq);
  assign ibus_addr = {pc_word, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_state <= FIdle;
      pc_word     <= '0;
      inst        <= '0;
      inst_valid  <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      unique case (fetch_state)
        FIdle: begin
          if (pc_valid) begin
            pc_word     <= pc[XLEN-1:2];
            fetch_state <= FReq;
          end
        end
        FReq: begin
          if (ibus_gnt) begin
            // The bus may return read data in the same cycle as the grant.
            if (ibus_rvalid) begin
              inst        <= ibus_rdata;
              inst_valid  <= 1'b1;
              fetch_state <= FIdle;
            end else begin
              fetch_state <= FWait;
            end
          end
        end
        FWait: begin
          if (ibus_rvalid) begin
            inst        <= ibus_rdata;
            inst_valid  <= 1'b1;
            fetch_state <= FIdle;
          end
        end
        default: fetch_state <= FIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data side
  // ---------------------------------------------------------------------------
  data_state_e     data_state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct_q;
  logic            we_q;
  logic            is_b;
  logic            is_h;
  logic [1:0]      lane;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] load_ext;

  // funct[1:0] selects the size, and funct[2] selects zero-extension.
  // The encodings 011, 110 and 111 fall through to word.
  assign is_b = (funct_q[1:0] == 2'b00);
  assign is_h = (funct_q[1:0] == 2'b01);

  // Byte offset of the accessed lane. A halfword uses addr[1] only.
  always_comb begin
    lane = 2'b00;
    if (is_b) begin
      lane = addr_q[1:0];
    end else if (is_h) begin
      lane = {addr_q[1], 1'b0};
    end
  end

  assign i_ready   = (data_state == DIdle);
  assign dbus_req  = (data_state == DReq);
  assign dbus_addr = {addr_q[XLEN-1:2], 2'b00};
  assign dbus_we   = we_q;

  always_comb begin
    dbus_wstrb = 4'b0000;
    dbus_wdata = wdata_q;
    if (is_b) begin
      dbus_wdata = {4{wdata_q[7:0]}};
      if (we_q) dbus_wstrb = 4'b0001 << lane;
    end else if (is_h) begin
      dbus_wdata = {2{wdata_q[15:0]}};
      if (we_q) dbus_wstrb = 4'b0011 << lane;
    end else begin
      if (we_q) dbus_wstrb = 4'b1111;
    end
  end

  assign rshift = dbus_rdata >> {lane, 3'b000};

  always_comb begin
    load_ext = rshift;
    if (is_b) begin
      load_ext = funct_q[2] ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
    end else if (is_h) begin
      load_ext = funct_q[2] ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
    end
  end

`ifdef LADYBIRD_MEM_MISALIGN_EN
  logic acc_mis;
  logic misaligned_q;

  // A halfword is misaligned at an odd address. Any word-class funct is
  // misaligned when addr[1:0] is nonzero.
  assign acc_mis = ((i_funct[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_funct[1] == 1'b1) && (i_addr[1:0] != 2'b00));
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_state <= DIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct_q    <= 3'b010;
      we_q       <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
`ifdef LADYBIRD_MEM_MISALIGN_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
`ifdef LADYBIRD_MEM_MISALIGN_EN
      misaligned_q <= 1'b0;
`endif
      unique case (data_state)
        DIdle: begin
          if (i_valid) begin
            addr_q     <= i_addr;
            wdata_q    <= i_data;
            funct_q    <= i_funct;
            we_q       <= i_we;
            data_state <= DReq;
`ifdef LADYBIRD_MEM_MISALIGN_EN
            if (acc_mis) begin
              misaligned_q <= 1'b1;
              data_state   <= DMis;
            end
`endif
          end
        end
        DReq: begin
          if (dbus_gnt) begin
            if (we_q) begin
              data_state <= DIdle;
            end else if (dbus_rvalid) begin
              o_data     <= load_ext;
              o_valid    <= 1'b1;
              data_state <= DResp;
            end else begin
              data_state <= DWait;
            end
          end
        end
        DWait: begin
          if (dbus_rvalid) begin
            o_data     <= load_ext;
            o_valid    <= 1'b1;
            data_state <= DResp;
          end
        end
        DResp: begin
          if (o_ready) begin
            o_valid    <= 1'b0;
            data_state <= DIdle;
          end
        end
        DMis: begin
          // A misaligned store is dropped. A misaligned load answers with zero.
          if (we_q) begin
            data_state <= DIdle;
          end else begin
            o_data     <= '0;
            o_valid    <= 1'b1;
            data_state <= DResp;
          end
        end
        default: data_state <= DIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_mem_unit.sv
module tb_ladybird_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_addr = '0;
  logic [31:0] i_data = '0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct = 3'b000;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_ready = 1'b0;
  logic        ibus_req;
  logic        ibus_gnt = 1'b0;
  logic [31:0] ibus_addr;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        dbus_req;
  logic        dbus_gnt = 1'b0;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

  always #5 clk = ~clk;

  ladybird_mem_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .inst(inst), .inst_valid(inst_valid),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_data(i_data),
    .i_we(i_we), .i_funct(i_funct),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
    .ibus_req(ibus_req), .ibus_gnt(ibus_gnt), .ibus_addr(ibus_addr),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .dbus_req(dbus_req), .dbus_gnt(dbus_gnt), .dbus_addr(dbus_addr), .dbus_we(dbus_we),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .misaligned(misaligned)
  );

  // Drives one load through grant and read data. The caller is left at the
  // negedge after rvalid, when the result should be visible.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] funct,
                         input logic [31:0] rdata);
    i_valid = 1'b1; i_addr = addr; i_funct = funct; i_we = 1'b0; i_data = 32'hA5A5_A5A5;
    @(negedge clk);
    i_valid = 1'b0; dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = rdata;
    @(negedge clk);
    dbus_rvalid = 1'b0; dbus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({pc_ready, i_ready, ibus_req, dbus_req, inst_valid, o_valid, misaligned} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 1100000",
               {pc_ready, i_ready, ibus_req, dbus_req, inst_valid, o_valid, misaligned});
    end
    n_tests++;
    if (inst !== 32'h0 || o_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: inst=%h o_data=%h required 0/0", inst, o_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int pulses;
    pc = 32'h100; pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0; pc = 32'h0;
    n_tests++;
    if ({ibus_req, pc_ready} !== 2'b10 || ibus_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b ready=%b addr=%h required 1/0/00000100",
               ibus_req, pc_ready, ibus_addr);
    end
    @(negedge clk);
    n_tests++;
    if (ibus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_req_hold: req=%b required 1", ibus_req);
    end
    @(negedge clk);
    ibus_gnt = 1'b1;
    @(negedge clk);
    ibus_gnt = 1'b0;
    n_tests++;
    if (ibus_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_wait: req=%b inst_valid=%b required 0/0", ibus_req, inst_valid);
    end
    ibus_rvalid = 1'b1; ibus_rdata = 32'h0050_0093;
    @(negedge clk);
    ibus_rvalid = 1'b0; ibus_rdata = 32'hFFFF_FFFF;
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || pc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_data: valid=%b inst=%h ready=%b required 1/00500093/1",
               inst_valid, inst, pc_ready);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0 || inst !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL fetch_hold: extra pulses=%0d inst=%h required 0/00500093", pulses, inst);
    end
  endtask

  task automatic test_store();
    // SB at 0x2003
    i_valid = 1'b1; i_addr = 32'h2003; i_data = 32'h1234_5678; i_we = 1'b1; i_funct = FB;
    @(negedge clk);
    i_valid = 1'b0;
    n_tests++;
    if ({dbus_req, dbus_we, i_ready} !== 3'b110 || dbus_addr !== 32'h2000 ||
        dbus_wstrb !== 4'b1000 || dbus_wdata !== 32'h7878_7878) begin
      n_fail++;
      $display("FAIL sb_bus: req/we/rdy=%b addr=%h strb=%b wdata=%h required 110/2000/1000/78787878",
               {dbus_req, dbus_we, i_ready}, dbus_addr, dbus_wstrb, dbus_wdata);
    end
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    n_tests++;
    if (dbus_req !== 1'b0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_done: req=%b i_ready=%b required 0/1", dbus_req, i_ready);
    end
    @(negedge clk);
    dbus_rvalid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_no_ovalid: o_valid=%b required 0", o_valid);
    end
    // SH at 0x2002
    i_valid = 1'b1; i_addr = 32'h2002; i_data = 32'h1234_ABCD; i_we = 1'b1; i_funct = FH;
    @(negedge clk);
    i_valid = 1'b0;
    n_tests++;
    if (dbus_wstrb !== 4'b1100 || dbus_wdata !== 32'hABCD_ABCD || dbus_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL sh_bus: strb=%b wdata=%h addr=%h required 1100/abcdabcd/2000",
               dbus_wstrb, dbus_wdata, dbus_addr);
    end
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    // SW at 0x2004
    i_valid = 1'b1; i_addr = 32'h2004; i_data = 32'hCAFE_BABE; i_we = 1'b1; i_funct = FW;
    @(negedge clk);
    i_valid = 1'b0;
    n_tests++;
    if (dbus_wstrb !== 4'b1111 || dbus_wdata !== 32'hCAFE_BABE || dbus_addr !== 32'h2004) begin
      n_fail++;
      $display("FAIL sw_bus: strb=%b wdata=%h addr=%h required 1111/cafebabe/2004",
               dbus_wstrb, dbus_wdata, dbus_addr);
    end
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
  endtask

  task automatic test_loads();
    do_load(32'h2001, FB, 32'h0000_F000);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL lb: o_valid=%b o_data=%h required 1/fffffff0", o_valid, o_data);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_consume: o_valid=%b i_ready=%b required 0/1", o_valid, i_ready);
    end
    do_load(32'h2001, FBU, 32'h0000_F000);
    n_tests++;
    if (o_data !== 32'h0000_00F0) begin
      n_fail++;
      $display("FAIL lbu: o_data=%h required 000000f0", o_data);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    // LH with back-pressure
    do_load(32'h2002, FH, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== 32'hFFFF_8000 || i_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL lh_hold[%0d]: o_valid=%b o_data=%h i_ready=%b required 1/ffff8000/0",
                 i, o_valid, o_data, i_ready);
      end
      @(negedge clk);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lh_release: o_valid=%b i_ready=%b required 0/1", o_valid, i_ready);
    end
    do_load(32'h2002, FHU, 32'h8000_0000);
    n_tests++;
    if (o_data !== 32'h0000_8000) begin
      n_fail++;
      $display("FAIL lhu: o_data=%h required 00008000", o_data);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    // Undefined funct 111 behaves as a word load.
    do_load(32'h2000, 3'b111, 32'h8765_4321);
    n_tests++;
    if (o_data !== 32'h8765_4321) begin
      n_fail++;
      $display("FAIL funct111_as_w: o_data=%h required 87654321", o_data);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    pc = 32'h200; pc_valid = 1'b1;
    i_valid = 1'b1; i_addr = 32'h3000; i_funct = FW; i_we = 1'b0;
    @(negedge clk);
    pc_valid = 1'b0; i_valid = 1'b0;
    n_tests++;
    if ({ibus_req, dbus_req} !== 2'b11 || ibus_addr !== 32'h200 || dbus_addr !== 32'h3000 ||
        dbus_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL conc_req: reqs=%b iaddr=%h daddr=%h strb=%b required 11/200/3000/0000",
               {ibus_req, dbus_req}, ibus_addr, dbus_addr, dbus_wstrb);
    end
    // Read data arriving in the grant cycle.
    ibus_gnt = 1'b1; ibus_rvalid = 1'b1; ibus_rdata = 32'hAAAA_5555;
    @(negedge clk);
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0;
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'hAAAA_5555 || dbus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_fetch: valid=%b inst=%h dbus_req=%b required 1/aaaa5555/1",
               inst_valid, inst, dbus_req);
    end
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 32'h1357_9BDF || inst !== 32'hAAAA_5555) begin
      n_fail++;
      $display("FAIL conc_load: o_valid=%b o_data=%h inst=%h required 1/13579bdf/aaaa5555",
               o_valid, o_data, inst);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    pc = 32'h300; pc_valid = 1'b1;
    i_valid = 1'b1; i_addr = 32'h2000; i_funct = FW; i_we = 1'b0;
    @(negedge clk);
    pc_valid = 1'b0; i_valid = 1'b0;
    n_tests++;
    if ({ibus_req, dbus_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_pre: reqs=%b required 11", {ibus_req, dbus_req});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ibus_req, dbus_req, pc_ready, i_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL rst_mid_async: req/req/rdy/rdy=%b required 0011",
               {ibus_req, dbus_req, pc_ready, i_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    ibus_rvalid = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_2222;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ibus_rvalid = 1'b0; dbus_rvalid = 1'b0;
      if (o_valid === 1'b1 || inst_valid === 1'b1 || dbus_req === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_resp: spurious cycles=%0d required 0", pulses);
    end
  endtask

  task automatic test_misalign();
    i_valid = 1'b1; i_addr = 32'h2002; i_funct = FW; i_we = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
`ifdef LADYBIRD_MEM_MISALIGN_EN
    n_tests++;
    if (misaligned !== 1'b1 || dbus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_pulse: misaligned=%b dbus_req=%b required 1/0", misaligned, dbus_req);
    end
    @(negedge clk);
    n_tests++;
    if (misaligned !== 1'b0 || dbus_req !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_resp: mis=%b req=%b o_valid=%b o_data=%h required 0/0/1/00000000",
               misaligned, dbus_req, o_valid, o_data);
    end
`else
    n_tests++;
    if (misaligned !== 1'b0 || dbus_req !== 1'b1 || dbus_addr !== 32'h2000 ||
        dbus_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL lw_unaligned_bus: mis=%b req=%b addr=%h strb=%b required 0/1/2000/0000",
               misaligned, dbus_req, dbus_addr, dbus_wstrb);
    end
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 32'hCAFE_F00D || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_unaligned_data: o_valid=%b o_data=%h mis=%b required 1/cafef00d/0",
               o_valid, o_data, misaligned);
    end
`endif
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_loads();
    test_concurrent();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
